// File: rtl/dmem_responder.sv
// Byte-serial data memory responder: accepts one 8-byte access, transfers one byte
// per cycle in little-endian order, then holds the response until it is consumed.
module dmem_responder #(
   parameter int MEM_BYTES = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_error,
   output logic        busy
);

   localparam int          AW         = $clog2(MEM_BYTES);
   localparam logic [63:0] LAST_LEGAL = 64'(MEM_BYTES - 8);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2:0]      cnt;
   logic            accept;
   logic            addr_ok;
   logic            write_q;
   logic [AW-1:0]   addr_q;
   logic [63:0]     wdata_q;
   logic [63:0]     rdata_q;
   logic            err_q;
   logic [AW-1:0]   mem_idx;
   logic [5:0]      bit_base;
   logic [7:0]      mem [MEM_BYTES];

   // Full 64-bit compare so huge addresses never alias into the array.
   assign addr_ok  = (req_addr <= LAST_LEGAL);
   assign mem_idx  = addr_q + AW'(cnt);
   assign bit_base = {cnt, 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            accept    = req_valid;
            if (req_valid) begin
               state_nxt = addr_ok ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            if (cnt == 3'd7) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are only meaningful after acceptance, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         write_q <= req_write;
         addr_q  <= req_addr[AW-1:0];
         wdata_q <= req_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= 3'd0;
         err_q   <= 1'b0;
         rdata_q <= 64'd0;
      end else if (accept) begin
         cnt     <= 3'd0;
         err_q   <= !addr_ok;
         rdata_q <= 64'd0;
      end else if (state == ACCESS) begin
         cnt <= cnt + 3'd1;
         if (!write_q) begin
            rdata_q[bit_base +: 8] <= mem[mem_idx];
         end
      end
   end

   // Array is never reset; a reset mid-access simply stops further byte writes.
   always_ff @(posedge clk) begin
      if (state == ACCESS && write_q) begin
         mem[mem_idx] <= wdata_q[bit_base +: 8];
      end
   end

   assign rsp_rdata = rsp_valid ? rdata_q : 64'd0;
   assign rsp_error = rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: expected responses are queued at
// request acceptance and compared when the response is handed over.
module tb_dmem_responder;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_error;
   logic        busy;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   dmem_responder #(.MEM_BYTES(2048)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer a request from IDLE; returns 1 ns after the acceptance edge.
   task automatic send(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] er, input logic ee, input int el, input bit push);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      if (push) sb.push_back('{er, ee, el});
      #1 req_valid = 1'b0;
   endtask

   // Wait for the response, optionally stall it for 'hold' cycles, then consume it.
   task automatic recv(input int hold);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         chk("busy_wait", {63'd0, busy}, 64'd1);
         @(negedge clk);
         n++;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 64'(sb.size()), 64'd1);
         e = '{64'd0, 1'b0, 0};
      end else begin
         e = sb.pop_front();
      end
      chk("latency", 64'(n), 64'(e.lat));
      chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_error", {63'd0, rsp_error}, {63'd0, e.err});
      chk("req_ready_resp", {63'd0, req_ready}, 64'd0);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = 64'h10;
         req_wdata = 64'hDEADBEEFCAFEF00D;
         @(negedge clk);
         chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
         chk("hold_rdata", rsp_rdata, e.rdata);
         chk("hold_error", {63'd0, rsp_error}, {63'd0, e.err});
         chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
         chk("hold_busy", {63'd0, busy}, 64'd1);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 64'd0;
      req_wdata = 64'd0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_rdata", rsp_rdata, 64'd0);
      chk("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

      // Aligned write then read back, with a stalled response and ignored request.
      send(1'b1, 64'h10, 64'h1122334455667788, 64'd0, 1'b0, 8, 1'b1);
      recv(0);
      send(1'b0, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, 8, 1'b1);
      recv(5);
      send(1'b0, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, 8, 1'b1);
      recv(0);

      // Unaligned read straddling two writes.
      send(1'b1, 64'h18, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 8, 1'b1);
      recv(0);
      send(1'b0, 64'h14, 64'd0, 64'hFFFFFFFF11223344, 1'b0, 8, 1'b1);
      recv(0);

      // Top-of-memory boundary.
      send(1'b1, 64'd2040, 64'h0123456789ABCDEF, 64'd0, 1'b0, 8, 1'b1);
      recv(0);
      send(1'b0, 64'd2041, 64'd0, 64'd0, 1'b1, 0, 1'b1);
      recv(0);
      send(1'b1, 64'd2041, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 0, 1'b1);
      recv(0);
      send(1'b0, 64'd2040, 64'd0, 64'h0123456789ABCDEF, 1'b0, 8, 1'b1);
      recv(0);
      send(1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 1'b1, 0, 1'b1);
      recv(0);

      // Reset after three bytes of a write.
      send(1'b1, 64'h40, 64'd0, 64'd0, 1'b0, 8, 1'b1);
      recv(0);
      send(1'b1, 64'h40, 64'hAAAAAAAAAAAAAAAA, 64'd0, 1'b0, 8, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_access_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_access_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(1'b0, 64'h40, 64'd0, 64'h0000000000AAAAAA, 1'b0, 8, 1'b1);
      recv(0);

      // Reset while a response is pending.
      send(1'b0, 64'h40, 64'd0, 64'h0000000000AAAAAA, 1'b0, 8, 1'b1);
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_resp_valid", {63'd0, rsp_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_resp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_resp_rdata", rsp_rdata, 64'd0);
      if (sb.size() > 0) void'(sb.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
      send(1'b0, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, 8, 1'b1);
      recv(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter: MEM_BYTES, 2048, size of byte-addressed data memory.
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: req_valid  in  1  requester offers an access.
REQ-005 SHALL have port: req_ready  out  1  responder accepts the offered access this cycle.
REQ-006 SHALL have port: req_write  in  1  1 = write (rmmovq/call/pushq), 0 = read (mrmovq/ret/popq).
REQ-007 SHALL have port: req_addr  in  64  starting byte address.
REQ-008 SHALL have port: req_wdata  in  64  write data, little-endian.
REQ-009 SHALL have port: rsp_valid  out  1  response available.
REQ-010 SHALL have port: rsp_ready  in  1  requester consumes the response.
REQ-011 SHALL have port: rsp_rdata  out  64  read data; 0 for writes and errors.
REQ-012 SHALL have port: rsp_error  out  1  address fault (feeds stat ADR bit).
REQ-013 SHALL have port: busy  out  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge with req_valid & req_ready; req_write, req_addr, req_wdata captured at that edge.
REQ-016 An address SHALL be legal iff req_addr <= MEM_BYTES-8, compared at full 64 bits; no wrap-around, no alignment requirement.
REQ-017 Illegal address: IDLE->RESP at the acceptance edge, rsp_error=1, rsp_rdata=0, no memory byte modified.
REQ-018 Legal address: IDLE->ACCESS at the acceptance edge, 3-bit byte counter cleared to 0.
REQ-019 In ACCESS, each edge SHALL transfer one byte k (k=0..7): write mem[addr+k] <= wdata[8k+7:8k], or read rdata[8k+7:8k] <= mem[addr+k].
REQ-020 After byte 7 is transferred, ACCESS->RESP; rsp_valid first visible 8 cycles after the acceptance edge, rsp_error=0.
REQ-021 In RESP, rsp_valid, rsp_rdata, and rsp_error SHALL remain stable until an edge with rsp_ready=1, then RESP->IDLE.
REQ-022 A new request SHALL NOT be accepted in the cycle rsp_ready is consumed; the earliest acceptance is the following cycle (IDLE).
REQ-023 req_* inputs SHALL be ignored outside IDLE; the requester holds them stable while req_valid & !req_ready.
REQ-024 Memory array SHALL NOT be reset; contents are undefined until written, retained across rst_n.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, req_ready=1 (once released), rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, byte counter=0.
REQ-026 Reset during ACCESS SHALL abandon the access without a response; bytes already written remain, the rest remain unchanged.
REQ-027 Reset during RESP SHALL discard the pending response.

Verification
REQ-028 Write 0x1122334455667788 @0x10 -> rsp_valid 8 cycles after accept, error 0; mem[0x10]=0x88 ... mem[0x17]=0x11; read @0x10 returns 0x1122334455667788.
REQ-029 Write @2040 -> OK; read @2041 -> rsp_valid on the cycle after accept, rsp_error=1, rsp_rdata=0; write @2041 leaves mem[2041..2047] unchanged.
REQ-030 Read @0xFFFFFFFFFFFFFFFC -> rsp_error=1 (no wrap to low addresses).
REQ-031 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata/rsp_error stable, req_ready=0, busy=1; concurrent req_valid not accepted.
REQ-032 Write 0xAAAAAAAAAAAAAAAA @0x40 over zeroed memory, assert rst_n=0 after byte 2 -> mem[0x40..0x42]=0xAA, mem[0x43..0x47]=0x00, rsp_valid=0.
REQ-033 Unaligned read @0x14 after REQ-028 write and write 0xFFFFFFFFFFFFFFFF @0x18 -> returns 0xFFFFFFFF11223344.
